// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-outstanding memory port,
// with starvation-bounded data priority and a BUSY timeout that sets a sticky bus error.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_din,
  input  logic [2:0]  dm_rd_ctrl,
  input  logic [2:0]  dm_wr_ctrl,
  output logic        dm_done,
  output logic [63:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [2:0]  mem_rd_ctrl,
  output logic [2:0]  mem_wr_ctrl,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  localparam int unsigned BW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t        state, state_next;
  logic [2:0]    wait_cnt;
  logic [BW-1:0] busy_cnt;
  logic          grant_if, grant_dm, finish, abort;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_done;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_next = state;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        // No grant while any done pulse is high: a held req cannot re-issue and
        // the data burst is not broken up by the fetch sliding into the gap.
        if (!if_valid && !dm_done) begin
          if (dm_req && !(if_req && wait_cnt == 3'(MAX_WAIT))) begin
            grant_dm   = 1'b1;
            state_next = DM_BUSY;
          end else if (if_req) begin
            grant_if   = 1'b1;
            state_next = IF_BUSY;
          end
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ready) begin
          finish = 1'b1;
        end else if (busy_cnt == BW'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end
        if (finish || abort) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, and all state updates use non-blocking assignment.
    if (rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_rd_ctrl <= '0;
      mem_wr_ctrl <= '0;
      if_valid    <= 1'b0;
      if_rdata    <= '0;
      dm_done     <= 1'b0;
      dm_rdata    <= '0;
      bus_err     <= 1'b0;
      wait_cnt    <= '0;
      busy_cnt    <= '0;
    end else begin
      state    <= state_next;
      if_valid <= 1'b0;
      dm_done  <= 1'b0;

      if (grant_if) begin
        mem_req     <= 1'b1;
        mem_addr    <= if_addr;
        mem_wdata   <= '0;
        mem_rd_ctrl <= 3'b011;
        mem_wr_ctrl <= 3'b000;
        busy_cnt    <= '0;
        wait_cnt    <= '0;
      end

      if (grant_dm) begin
        mem_req     <= 1'b1;
        mem_addr    <= dm_addr;
        mem_wdata   <= dm_din;
        mem_rd_ctrl <= dm_rd_ctrl;
        mem_wr_ctrl <= dm_wr_ctrl;
        busy_cnt    <= '0;
        if (if_req && wait_cnt < 3'(MAX_WAIT)) begin
          wait_cnt <= wait_cnt + 3'd1;
        end
      end

      if (finish || abort) begin
        mem_req <= 1'b0;
        if (state == IF_BUSY) begin
          if_valid <= 1'b1;
          if_rdata <= finish ? mem_rdata[31:0] : 32'd0;
        end else begin
          dm_done  <= 1'b1;
          dm_rdata <= finish ? mem_rdata : 64'd0;
        end
        if (abort) begin
          bus_err <= 1'b1;
        end
      end else if (state != IDLE) begin
        busy_cnt <= busy_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_req;
  logic [63:0] dm_addr;
  logic [63:0] dm_din;
  logic [2:0]  dm_rd_ctrl;
  logic [2:0]  dm_wr_ctrl;
  logic        dm_done;
  logic [63:0] dm_rdata;
  logic        dm_stall;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [2:0]  mem_rd_ctrl;
  logic [2:0]  mem_wr_ctrl;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  // Model state: consecutive data wins against a waiting fetch, and whether the
  // previous round ended in a done cycle (during which nothing is granted).
  int model_wait = 0;
  bit prev_done  = 1'b0;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_din(dm_din), .dm_rd_ctrl(dm_rd_ctrl),
    .dm_wr_ctrl(dm_wr_ctrl), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_ctrl(mem_rd_ctrl), .mem_wr_ctrl(mem_wr_ctrl), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One arbitration round: drive requests, expect the model's winner to be granted,
  // serve it after `delay` wait cycles, and check the completion.
  task automatic do_round(input bit rif, input bit rdm, input int delay,
                          input logic [63:0] din, input logic [2:0] rdc,
                          input logic [2:0] wrc, output bit got_fetch);
    logic [63:0] word;
    logic [63:0] e_addr, e_wdata;
    logic [2:0]  e_rd, e_wr;
    bit          fetch_wins;
    word       = {$urandom, $urandom};
    if_req     = rif;
    dm_req     = rdm;
    if_addr    = {$urandom, $urandom};
    dm_addr    = {$urandom, $urandom};
    dm_din     = din;
    dm_rd_ctrl = rdc;
    dm_wr_ctrl = wrc;

    fetch_wins = rif && (!rdm || model_wait == MAX_WAIT);
    if (fetch_wins) begin
      model_wait = 0;
      e_addr = if_addr; e_wdata = 64'd0; e_rd = 3'b011; e_wr = 3'b000;
    end else begin
      if (rif && model_wait < MAX_WAIT) model_wait++;
      e_addr = dm_addr; e_wdata = din; e_rd = rdc; e_wr = wrc;
    end

    if (prev_done) begin
      tick();
      check("no_grant_in_done_cycle", mem_req, 0);
    end
    tick();
    check("grant_mem_req", mem_req, 1);
    check("grant_mem_addr", mem_addr, e_addr);
    check("grant_mem_wdata", mem_wdata, e_wdata);
    check("grant_mem_rd_ctrl", mem_rd_ctrl, e_rd);
    check("grant_mem_wr_ctrl", mem_wr_ctrl, e_wr);
    check("busy_if_stall", if_stall, rif);
    check("busy_dm_stall", dm_stall, rdm);

    for (int i = 0; i < delay; i++) tick();
    if (delay > 0) begin
      check("busy_stable_addr", mem_addr, e_addr);
      check("busy_stable_req", mem_req, 1);
    end

    mem_rdata = word;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom};

    check("done_if_valid", if_valid, fetch_wins);
    check("done_dm_done", dm_done, !fetch_wins);
    check("done_mem_req", mem_req, 0);
    if (fetch_wins) check("done_if_rdata", if_rdata, word[31:0]);
    else            check("done_dm_rdata", dm_rdata, word);
    got_fetch = if_valid;
    prev_done = 1'b1;
  endtask

  initial begin
    bit f;
    bit rif, rdm;

    rst = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_addr = '0; dm_din = '0;
    dm_rd_ctrl = '0; dm_wr_ctrl = '0; mem_rdata = '0; mem_ready = 0;
    tick();
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b0;
    tick();

    // Single fetch, zero-wait memory.
    if_req  = 1'b1;
    if_addr = 64'h100;
    tick();
    check("fetch_mem_req", mem_req, 1);
    check("fetch_mem_addr", mem_addr, 64'h100);
    check("fetch_rd_ctrl", mem_rd_ctrl, 3'b011);
    check("fetch_if_stall", if_stall, 1);
    mem_rdata = 64'hDEAD_BEEF_0000_0013;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("fetch_if_valid", if_valid, 1);
    check("fetch_if_rdata", if_rdata, 32'h0000_0013);
    check("fetch_stall_on_done", if_stall, 0);
    if_req = 1'b0;
    tick();
    check("fetch_valid_one_cycle", if_valid, 0);
    check("fetch_rdata_hold", if_rdata, 32'h0000_0013);

    // Simultaneous store and fetch: data first, then fetch with zero write data.
    do_round(1, 1, 0, 64'hAB, 3'b000, 3'b001, f);
    check("simul_first_is_data", f, 0);
    do_round(1, 0, 1, 64'h0, 3'b000, 3'b000, f);
    check("simul_second_is_fetch", f, 1);

    // Both held high: four data grants, then the starved fetch, repeating.
    for (int i = 0; i < 10; i++) begin
      do_round(1, 1, $urandom_range(0, 2), {$urandom, $urandom}, 3'($urandom), 3'($urandom), f);
      check("starve_pattern", f, (i % 5) == 4);
    end

    // Randomized rounds against the model.
    for (int i = 0; i < 30; i++) begin
      rif = 1'($urandom);
      rdm = 1'($urandom);
      if (!rif && !rdm) rdm = 1'b1;
      do_round(rif, rdm, $urandom_range(0, 4), {$urandom, $urandom},
               3'($urandom), 3'($urandom), f);
    end

    // Memory never ready: abort after the timeout with zeroed rdata.
    if_req  = 1'b0;
    dm_req  = 1'b1;
    dm_addr = 64'h2000;
    tick();
    check("to_no_grant_in_done", mem_req, 0);
    tick();
    check("to_grant", mem_req, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("to_no_done_before_limit", dm_done, 0);
    check("to_still_busy", mem_req, 1);
    tick();
    check("to_done", dm_done, 1);
    check("to_rdata_zero", dm_rdata, 0);
    check("to_bus_err", bus_err, 1);
    check("to_mem_req_drop", mem_req, 0);
    dm_req = 1'b0;
    tick();
    check("to_done_one_cycle", dm_done, 0);
    check("to_bus_err_sticky", bus_err, 1);
    prev_done = 1'b0;
    do_round(1, 0, 2, 64'h0, 3'b000, 3'b000, f);
    check("to_bus_err_after_round", bus_err, 1);

    // mem_ready while idle must be ignored.
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    check("idle_ready_if_valid", if_valid, 0);
    check("idle_ready_dm_done", dm_done, 0);
    check("idle_ready_mem_req", mem_req, 0);

    // Reset during the second BUSY cycle.
    if_req  = 1'b1;
    if_addr = 64'h3000;
    tick();
    check("rstb_grant", mem_req, 1);
    tick();
    rst = 1'b1;
    tick();
    check("rstb_mem_req", mem_req, 0);
    check("rstb_if_valid", if_valid, 0);
    check("rstb_bus_err", bus_err, 0);
    check("rstb_mem_addr", mem_addr, 0);
    check("rstb_rd_ctrl", mem_rd_ctrl, 0);
    check("rstb_if_rdata", if_rdata, 0);
    check("rstb_dm_rdata", dm_rdata, 0);
    rst    = 1'b0;
    if_req = 1'b0;
    tick();
    check("rstb_no_done", if_valid, 0);
    model_wait = 0;
    prev_done  = 1'b0;
    do_round(0, 1, 1, {$urandom, $urandom}, 3'($urandom), 3'($urandom), f);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
